hw_stack: RTL and testbench

HW_STACK -- requirements
Module: hw_stack

---
 rtl/hw_stack.sv | 113 +++++++++++
 tb/tb_hw_stack.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hw_stack.sv
// Parameterised LIFO stack with registered pop data, occupancy count and
// sticky overflow/underflow flags. Single clock, synchronous active-high reset.
module hw_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [PW-1:0]    top_idx;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = count_q[PW-1:0];
    top_idx     = count_q[PW-1:0] - PW'(1);

    unique case ({push, pop})
      2'b10: begin
        if (full_q) begin
          overflow_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_q) begin
          underflow_d = 1'b1;
        end else begin
          data_out_d = mem[top_idx];
          count_d    = count_q - CW'(1);
        end
      end
      2'b11: begin
        // Simultaneous push/pop swaps the top word; on an empty stack it passes through.
        if (empty_q) begin
          data_out_d = data_in;
        end else begin
          data_out_d = mem[top_idx];
          mem_we     = 1'b1;
          mem_waddr  = top_idx;
        end
      end
      default: ;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      count_q     <= '0;
      data_out_q  <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is not reset; entries above count are never read before being written.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_hw_stack.sv
// Directed self-checking bench for hw_stack (WIDTH=8, DEPTH=16): LIFO order,
// full/overflow, empty/underflow, simultaneous push+pop and reset priority.
module tb_hw_stack;

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  hw_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Apply one edge of stimulus, then sample 1 ns after the edge.
  task automatic cycle(input logic r, input logic p, input logic q, input logic [7:0] d);
    reset = r; push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_lifo_order();
    logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, words[i]);
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL lifo_push_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== words[2 - i]) begin errors++; $display("FAIL lifo_pop_data[%0d] got=%h exp=%h", i, data_out, words[2 - i]); end
      checks++; if (count !== 5'(2 - i)) begin errors++; $display("FAIL lifo_pop_count[%0d] got=%0d exp=%0d", i, count, 2 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got=%b exp=1", empty); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL lifo_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_fill_overflow();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(i));
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 15)); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h0F) begin errors++; $display("FAIL ovf_pop_data got=%h exp=0f", data_out); end
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL ovf_pop_count got=%0d exp=15", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_pop_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_push_pop_full();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    cycle(1'b0, 1'b1, 1'b1, 8'hC3);
    checks++; if (data_out !== 8'h8F) begin errors++; $display("FAIL ppfull_data got=%h exp=8f", data_out); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ppfull_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ppfull_overflow got=%b exp=0", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ppfull_full got=%b exp=1", full); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL ppfull_pop_data got=%h exp=c3", data_out); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h8E) begin errors++; $display("FAIL ppfull_pop2_data got=%h exp=8e", data_out); end
    checks++; if (count !== 5'd14) begin errors++; $display("FAIL ppfull_pop2_count got=%0d exp=14", count); end
  endtask

  task automatic test_underflow();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL unf_data got=%h exp=00", data_out); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL unf_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_empty got=%b exp=1", empty); end
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL unf_push_empty got=%b exp=0", empty); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL unf_pop_data got=%h exp=5a", data_out); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL unf_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_push_pop_nonempty();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h10);
    cycle(1'b0, 1'b1, 1'b0, 8'h20);
    cycle(1'b0, 1'b1, 1'b1, 8'h99);
    checks++; if (data_out !== 8'h20) begin errors++; $display("FAIL pp_data got=%h exp=20", data_out); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL pp_count got=%0d exp=2", count); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL pp_flags got=%b exp=00", {overflow, underflow}); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (data_out !== 8'h20) begin errors++; $display("FAIL pp_hold got=%h exp=20", data_out); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h99) begin errors++; $display("FAIL pp_pop1 got=%h exp=99", data_out); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h10) begin errors++; $display("FAIL pp_pop2 got=%h exp=10", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_push_pop_empty();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    checks++; if (data_out !== 8'h77) begin errors++; $display("FAIL ppe_data got=%h exp=77", data_out); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ppe_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ppe_empty got=%b exp=1", empty); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL ppe_flags got=%b exp=00", {overflow, underflow}); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h77) begin errors++; $display("FAIL ppe_unf_hold got=%h exp=77", data_out); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL ppe_unf_flag got=%b exp=1", underflow); end
  endtask

  task automatic test_reset_priority();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL rp_pre_count got=%0d exp=5", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rp_pre_overflow got=%b exp=1", overflow); end
    checks++; if (data_out !== 8'h45) begin errors++; $display("FAIL rp_pre_data got=%h exp=45", data_out); end
    cycle(1'b1, 1'b1, 1'b0, 8'hE1);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rp_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rp_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rp_overflow got=%b exp=0", overflow); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rp_data got=%h exp=00", data_out); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL rp_underflow got=%b exp=1", underflow); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rp_post_count got=%0d exp=0", count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rp_post_data got=%h exp=00", data_out); end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    test_reset();
    test_lifo_order();
    test_fill_overflow();
    test_push_pop_full();
    test_underflow();
    test_push_pop_nonempty();
    test_push_pop_empty();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
